// File: rtl/audio_link_pkg.sv
// Shared types and helpers for the audio-to-UART link.
// Holds the frame FSM state encoding, the default sync byte, and the
// byte extraction helper used by the frame scheduler.
package audio_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SEQ   = 3'd2,
    ST_DATA  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DRAIN = 3'd5
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte k of a sample, counted from the MSB end. The sample is passed
  // left-justified in 32 bits so one helper serves every sample width.
  function automatic logic [7:0] sample_byte(input logic [31:0] sample,
                                             input logic [1:0]  k);
    logic [31:0] shifted;
    shifted = sample << {k, 3'b000};
    return shifted[31:24];
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Bundle of the audio sample input and the uart_transmit handshake.
//
// Handshake: the scheduler raises uart_trigger_out for exactly one cycle
// with uart_data_out stable; the transmitter answers by raising
// uart_busy_in (one cycle later) and holds it until the byte is on the
// wire. A new trigger is only issued after busy has been seen low.
// audio_valid_in is a one-cycle pulse qualifying audio_in; there is no
// back-pressure, so a sample set arriving mid-frame is dropped.
interface uart_frame_scheduler_if #(
  parameter int MICS         = 2,
  parameter int SAMPLE_WIDTH = 24
);
  logic [MICS-1:0][SAMPLE_WIDTH-1:0] audio_in;
  logic                              audio_valid_in;
  logic                              uart_busy_in;
  logic [7:0]                        uart_data_out;
  logic                              uart_trigger_out;

  // Scheduler side.
  modport master (
    input  audio_in,
    input  audio_valid_in,
    input  uart_busy_in,
    output uart_data_out,
    output uart_trigger_out
  );

  // Environment side: sample source plus transmitter.
  modport slave (
    output audio_in,
    output audio_valid_in,
    output uart_busy_in,
    input  uart_data_out,
    input  uart_trigger_out
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts single-cycle events and sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  // Increment on each event until the counter is full.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_out <= '0;
    end else if (inc_in && (count_out != '1)) begin
      count_out <= count_out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frame scheduler between tdm_receive and uart_transmit.
// Latches one sample set per frame and sends: sync byte, sequence number,
// then the top BYTES_PER_SAMPLE bytes of each enabled mic, MSB first.
// Every byte goes send -> HOLD (one cycle, covers busy rise) -> DRAIN
// (wait busy low) before the next byte state is entered.
module uart_frame_scheduler
  import audio_link_pkg::*;
#(
  parameter int         MICS             = 2,
  parameter int         SAMPLE_WIDTH     = 24,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  uart_frame_scheduler_if.master        bus,
  input  logic                          enable_in,
  input  logic [MICS-1:0]               mic_mask_in,
  output logic                          frame_active_out,
  output logic [7:0]                    drop_count_out,
  output frame_state_t                  dbg_state
);

  localparam int         MIC_W     = (MICS > 1) ? $clog2(MICS) : 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_SAMPLE - 1);

  frame_state_t                      state_q;
  frame_state_t                      next_q;
  logic [MICS-1:0][SAMPLE_WIDTH-1:0] samples_q;
  logic [MICS-1:0]                   mask_q;
  logic [MIC_W-1:0]                  mic_q;
  logic [1:0]                        byte_q;
  logic [7:0]                        seq_q;
  logic [7:0]                        data_q;
  logic                              trig_q;
  logic                              active_q;

  logic                              first_found;
  logic [MIC_W-1:0]                  first_mic;
  logic                              next_found;
  logic [MIC_W-1:0]                  next_mic;
  logic [31:0]                       aligned;
  logic [7:0]                        data_byte;
  logic                              reject_evt;

  // Locate the lowest enabled mic, and the lowest enabled mic above the
  // current one, so masked-off mics cost no idle cycles.
  always_comb begin
    first_found = 1'b0;
    first_mic   = '0;
    next_found  = 1'b0;
    next_mic    = '0;
    for (int i = MICS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_found = 1'b1;
        first_mic   = MIC_W'(i);
      end
      if (mask_q[i] && (i > int'(mic_q))) begin
        next_found = 1'b1;
        next_mic   = MIC_W'(i);
      end
    end
  end

  // Byte k of the current mic, taken from the MSB end of its sample.
  always_comb begin
    aligned   = 32'(samples_q[mic_q]) << (32 - SAMPLE_WIDTH);
    data_byte = sample_byte(aligned, byte_q);
  end

  // Frame sequencing FSM with registered UART outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      next_q    <= ST_IDLE;
      samples_q <= '0;
      mask_q    <= '0;
      mic_q     <= '0;
      byte_q    <= '0;
      seq_q     <= '0;
      data_q    <= '0;
      trig_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.audio_valid_in && enable_in) begin
            samples_q <= bus.audio_in;
            mask_q    <= mic_mask_in;
            mic_q     <= '0;
            byte_q    <= '0;
            active_q  <= 1'b1;
            state_q   <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (!bus.uart_busy_in) begin
            data_q  <= SYNC_BYTE;
            trig_q  <= 1'b1;
            next_q  <= ST_SEQ;
            state_q <= ST_HOLD;
          end
        end
        ST_SEQ: begin
          if (!bus.uart_busy_in) begin
            data_q  <= seq_q;
            trig_q  <= 1'b1;
            seq_q   <= seq_q + 8'd1;
            state_q <= ST_HOLD;
            if (first_found) begin
              mic_q  <= first_mic;
              next_q <= ST_DATA;
            end else begin
              next_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (!bus.uart_busy_in) begin
            data_q  <= data_byte;
            trig_q  <= 1'b1;
            state_q <= ST_HOLD;
            if (byte_q == LAST_BYTE) begin
              byte_q <= '0;
              if (next_found) begin
                mic_q  <= next_mic;
                next_q <= ST_DATA;
              end else begin
                next_q <= ST_IDLE;
              end
            end else begin
              byte_q <= byte_q + 2'd1;
              next_q <= ST_DATA;
            end
          end
        end
        ST_HOLD: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.uart_busy_in) begin
            state_q <= next_q;
            if (next_q == ST_IDLE) begin
              active_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A sample set that arrives while a frame is in flight is lost.
  assign reject_evt = bus.audio_valid_in && (state_q != ST_IDLE);

  sat_counter #(.WIDTH(8)) u_drop_counter (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .inc_in    (reject_evt),
    .count_out (drop_count_out)
  );

  assign bus.uart_data_out    = data_q;
  assign bus.uart_trigger_out = trig_q;
  assign frame_active_out     = active_q;
  assign dbg_state            = state_q;

endmodule
